// File: rtl/puf_eval_sequencer.sv
// Arbiter-PUF evaluation sequencer: loads a challenge, fires EVALS races with
// settle/relax gaps, and returns a majority-voted response with stability info.
module puf_eval_sequencer #(
  parameter int N          = 128,
  parameter int EVALS      = 7,
  parameter int SETTLE_CYC = 4,
  parameter int RACE_CYC   = 8,
  parameter int RELAX_CYC  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          chal_valid,
  output logic          chal_ready,
  input  logic [N-1:0]  chal_data,
  output logic [N-1:0]  puf_control,
  output logic          puf_launch,
  input  logic          puf_resp,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_bit,
  output logic          resp_stable,
  output logic [$clog2(EVALS+1)-1:0] resp_ones
);

  localparam int CW   = $clog2(EVALS + 1);
  localparam int PMAX = (SETTLE_CYC > RACE_CYC)
                        ? ((SETTLE_CYC > RELAX_CYC) ? SETTLE_CYC : RELAX_CYC)
                        : ((RACE_CYC > RELAX_CYC) ? RACE_CYC : RELAX_CYC);
  localparam int PW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LAUNCH,
    RELAX,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   phase;
  logic            phase_last;
  logic [CW-1:0]   evals_done;
  logic [CW-1:0]   ones;
  logic            sync1;
  logic            sync2;
  logic            accept;
  logic            last_eval;

  assign chal_ready = (state == IDLE) & rst_n;
  assign accept     = (state == IDLE) & chal_valid;
  assign last_eval  = (evals_done == CW'(EVALS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    phase_last = 1'b0;
    case (state)
      IDLE: begin
        if (chal_valid) state_nx = SETTLE;
      end
      SETTLE: begin
        phase_last = (phase == PW'(SETTLE_CYC - 1));
        if (phase_last) state_nx = LAUNCH;
      end
      LAUNCH: begin
        phase_last = (phase == PW'(RACE_CYC - 1));
        if (phase_last) state_nx = RELAX;
      end
      RELAX: begin
        phase_last = (phase == PW'(RELAX_CYC - 1));
        if (phase_last) state_nx = last_eval ? DONE : SETTLE;
      end
      DONE: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Launch is driven from the next state so it is high exactly while in LAUNCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      puf_control <= '0;
      puf_launch  <= 1'b0;
      phase       <= '0;
      evals_done  <= '0;
      ones        <= '0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_bit    <= 1'b0;
      resp_stable <= 1'b0;
      resp_ones   <= '0;
    end else begin
      sync1      <= puf_resp;
      sync2      <= sync1;
      puf_launch <= (state_nx == LAUNCH);

      if (state_nx != state || state == IDLE || state == DONE) phase <= '0;
      else                                                     phase <= phase + 1'b1;

      if (accept) begin
        puf_control <= chal_data;
        evals_done  <= '0;
        ones        <= '0;
      end

      if (state == LAUNCH && phase_last) ones <= ones + CW'(sync2);

      if (state == RELAX && phase_last) begin
        evals_done <= evals_done + 1'b1;
        if (last_eval) begin
          resp_valid  <= 1'b1;
          resp_ones   <= ones;
          resp_bit    <= (ones > CW'(EVALS >> 1));
          resp_stable <= (ones == '0) || (ones == CW'(EVALS));
        end
      end

      if (state == DONE && resp_ready) resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer with a behavioural arbiter chain that
// resolves each race to a preloaded per-race bit.
module tb_puf_eval_sequencer;

  localparam int N = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          chal_valid;
  logic          chal_ready;
  logic [N-1:0]  chal_data;
  logic [N-1:0]  puf_control;
  logic          puf_launch;
  logic          puf_resp;
  logic          resp_valid;
  logic          resp_ready;
  logic          resp_bit;
  logic          resp_stable;
  logic [2:0]    resp_ones;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [6:0] pattern = '0;
  int race_idx = 0;
  int pulses = 0;
  int width_err = 0;
  int hi_run = 0;
  int ctrl_err = 0;

  puf_eval_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chal_valid  (chal_valid),
    .chal_ready  (chal_ready),
    .chal_data   (chal_data),
    .puf_control (puf_control),
    .puf_launch  (puf_launch),
    .puf_resp    (puf_resp),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_bit    (resp_bit),
    .resp_stable (resp_stable),
    .resp_ones   (resp_ones)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Chain model: each launch edge resolves to the next preloaded race bit
  initial begin
    forever begin
      @(posedge puf_launch);
      puf_resp = (race_idx < 7) ? pattern[race_idx] : 1'b0;
      race_idx++;
      @(negedge puf_launch);
      #3 puf_resp = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (puf_launch === 1'b1) hi_run++;
      else if (hi_run != 0) begin
        pulses++;
        if (hi_run != 8) width_err++;
        hi_run = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a challenge and returns after the accept edge
  task automatic applyStimulus(input logic [N-1:0] data, input logic [6:0] pat, output int waits);
    pattern    = pat;
    race_idx   = 0;
    pulses     = 0;
    width_err  = 0;
    chal_data  = data;
    chal_valid = 1'b1;
    waits      = 0;
    while (chal_ready !== 1'b1 && waits < 300) begin
      tick();
      waits++;
    end
    checkOutput("accept_ready", chal_ready, 1'b1);
    tick();
    chal_valid = 1'b0;
    chal_data  = {$urandom, $urandom, $urandom, $urandom};
    checkOutput("ctrl_load", puf_control, data);
  endtask

  task automatic awaitResult(input logic [N-1:0] data, output int lat);
    ctrl_err = 0;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (puf_control !== data) ctrl_err++;
      if (resp_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int waits;
    int lat;
    int err;
    int v;
    logic [N-1:0] da;
    logic [N-1:0] db;

    rst_n      = 1'b0;
    chal_valid = 1'b0;
    chal_data  = '0;
    resp_ready = 1'b0;
    puf_resp   = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      chal_valid = 1'($urandom);
      chal_data  = {$urandom, $urandom, $urandom, $urandom};
      resp_ready = 1'($urandom);
      puf_resp   = 1'($urandom);
      tick();
    end
    checkOutput("rst_control", puf_control, '0);
    checkOutput("rst_launch", puf_launch, 1'b0);
    checkOutput("rst_valid", resp_valid, 1'b0);
    checkOutput("rst_bit", resp_bit, 1'b0);
    checkOutput("rst_stable", resp_stable, 1'b0);
    checkOutput("rst_ones", resp_ones, 3'd0);
    checkOutput("rst_ready", chal_ready, 1'b0);
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    puf_resp   = 1'b0;
    rst_n      = 1'b1;
    #1;
    checkOutput("post_rst_ready", chal_ready, 1'b1);
    tick();

    // Stable 1
    da = {16{8'hA5}};
    applyStimulus(da, 7'b1111111, waits);
    awaitResult(da, lat);
    checkOutput("s1_latency", lat, 112);
    checkOutput("s1_ctrl_hold", ctrl_err, 0);
    checkOutput("s1_pulses", pulses, 7);
    checkOutput("s1_widths", width_err, 0);
    checkOutput("s1_bit", resp_bit, 1'b1);
    checkOutput("s1_stable", resp_stable, 1'b1);
    checkOutput("s1_ones", resp_ones, 3'd7);
    checkOutput("s1_launch_done", puf_launch, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("s1_hs_valid", resp_valid, 1'b0);
    checkOutput("s1_hs_ready", chal_ready, 1'b1);

    // Noisy majority: 1,0,1,1,0,1,0
    da = {4{32'h1234_5678}};
    applyStimulus(da, 7'b0101101, waits);
    awaitResult(da, lat);
    checkOutput("n1_latency", lat, 112);
    checkOutput("n1_ones", resp_ones, 3'd4);
    checkOutput("n1_bit", resp_bit, 1'b1);
    checkOutput("n1_stable", resp_stable, 1'b0);

    // Backpressure with a pending challenge held by the producer
    db = {4{32'hDEAD_BEEF}};
    chal_data  = db;
    chal_valid = 1'b1;
    err = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_ones !== 3'd4 || resp_bit !== 1'b1 ||
          resp_stable !== 1'b0 || puf_launch !== 1'b0 || chal_ready !== 1'b0 ||
          puf_control !== da) err++;
    end
    checkOutput("bp_hold", err, 0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("bp_hs_valid", resp_valid, 1'b0);
    checkOutput("bp_idle_ready", chal_ready, 1'b1);
    // Noisy minority: 0,0,1,0,1,0,0
    applyStimulus(db, 7'b0010100, waits);
    checkOutput("bp_accept_next", waits, 0);
    awaitResult(db, lat);
    checkOutput("n2_latency", lat, 112);
    checkOutput("n2_ones", resp_ones, 3'd2);
    checkOutput("n2_bit", resp_bit, 1'b0);
    checkOutput("n2_stable", resp_stable, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset during the third launch
    da = {4{32'h0F0F_0F0F}};
    applyStimulus(da, 7'b1111111, waits);
    err = 0;
    while (race_idx < 3 && err < 300) begin
      tick();
      err++;
    end
    tick();
    tick();
    checkOutput("mr_launch_high", puf_launch, 1'b1);
    rst_n = 1'b0;
    tick();
    checkOutput("mr_launch_drop", puf_launch, 1'b0);
    checkOutput("mr_ready_low", chal_ready, 1'b0);
    checkOutput("mr_no_valid", resp_valid, 1'b0);
    checkOutput("mr_ones_clr", resp_ones, 3'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("mr_idle", chal_ready, 1'b1);
    err = 0;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (resp_valid !== 1'b0 || puf_launch !== 1'b0) err++;
    end
    checkOutput("mr_quiet", err, 0);
    db = {4{32'h8000_0001}};
    applyStimulus(db, 7'b0000000, waits);
    awaitResult(db, lat);
    checkOutput("mr_latency", lat, 112);
    checkOutput("mr_pulses", pulses, 7);
    checkOutput("mr_ones", resp_ones, 3'd0);
    checkOutput("mr_bit", resp_bit, 1'b0);
    checkOutput("mr_stable", resp_stable, 1'b1);
    resp_ready = 1'b1;
    tick();

    // Back-to-back with resp_ready tied high
    da = {4{32'hCAFE_F00D}};
    db = {4{32'h0BAD_C0DE}};
    applyStimulus(da, 7'b1111111, waits);
    awaitResult(da, lat);
    checkOutput("bb1_latency", lat, 112);
    checkOutput("bb1_ones", resp_ones, 3'd7);
    v = cyc;
    applyStimulus(db, 7'b0000001, waits);
    checkOutput("bb_gap", cyc - v, 2);
    awaitResult(db, lat);
    checkOutput("bb2_latency", lat, 112);
    checkOutput("bb2_ctrl_hold", ctrl_err, 0);
    checkOutput("bb2_ones", resp_ones, 3'd1);
    checkOutput("bb2_bit", resp_bit, 1'b0);
    checkOutput("bb2_stable", resp_stable, 1'b0);
    tick();
    checkOutput("bb2_hs_valid", resp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
